// File: rtl/bus_pkg.sv
// bus_pkg: shared constants and mode encodings for the bus arbiter slice.
//   BUS_WIDTH_DEF / BUS_NSRC_DEF : default data width and source count
//   bus_mode_e                   : mode input encoding (direct select / round-robin)
package bus_pkg;

  localparam int BUS_WIDTH_DEF = 16;
  localparam int BUS_NSRC_DEF  = 8;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } bus_mode_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority search.
//   req        : per-source request vector
//   last_grant : index of the most recent arbitration winner
//   winner     : first requesting index searching upward from last_grant+1, wrapping
//   any_req    : at least one request bit is set
module rr_pick #(
  parameter int NSRC = 8,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [SELW-1:0] last_grant,
  output logic [SELW-1:0] winner,
  output logic            any_req
);

  // Scan the NSRC candidates in rotated order; the first hit wins and later hits are ignored.
  always_comb begin
    int          cand_v;
    logic [SELW-1:0] cand_s;
    winner  = {SELW{1'b0}};
    any_req = 1'b0;
    cand_v  = 0;
    cand_s  = {SELW{1'b0}};
    for (int i = 1; i <= NSRC; i++) begin
      cand_v = int'(last_grant) + i;
      if (cand_v >= NSRC) begin
        cand_v = cand_v - NSRC;
      end else begin
        cand_v = cand_v;
      end
      cand_s = SELW'(cand_v);
      if (!any_req && req[cand_s]) begin
        any_req = 1'b1;
        winner  = cand_s;
      end else begin
        any_req = any_req;
      end
    end
  end

endmodule

// File: rtl/bus_arb.sv
// bus_arb: multi-source bus multiplexer with direct-select and round-robin modes.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   mode           : 0 = direct select via read_en/sel_valid, 1 = round-robin over req
//   read_en        : source index in direct mode
//   sel_valid      : direct-mode transfer strobe
//   src_data       : packed source words, source i on [i*WIDTH +: WIDTH]
//   req, lock      : arbitration requests, lock keeps the current owner while it requests
//   grant          : registered one-hot grant (zero when idle)
//   busout         : registered bus value, bus_src its source index
//   bus_valid      : one-cycle pulse for each new busout value
//   sel_err        : one-cycle pulse on an out-of-range direct select
module bus_arb
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH_DEF,
  parameter int NSRC  = BUS_NSRC_DEF,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  mode,
  input  logic [SELW-1:0]       read_en,
  input  logic                  sel_valid,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       req,
  input  logic                  lock,
  output logic [NSRC-1:0]       grant,
  output logic [WIDTH-1:0]      busout,
  output logic                  bus_valid,
  output logic [SELW-1:0]       bus_src,
  output logic                  sel_err
);

  logic [NSRC-1:0]  grant_r,      grant_nxt_s;
  logic [WIDTH-1:0] busout_r,     busout_nxt_s;
  logic             bus_valid_r,  bus_valid_nxt_s;
  logic [SELW-1:0]  bus_src_r,    bus_src_nxt_s;
  logic             sel_err_r,    sel_err_nxt_s;
  logic [SELW-1:0]  last_grant_r, last_grant_nxt_s;
  // Set when the previous cycle issued an arbitration grant; qualifies lock.
  logic             arb_hold_r,   arb_hold_nxt_s;

  logic [WIDTH-1:0] src_word_s [NSRC];
  logic [SELW-1:0]  winner_s;
  logic             any_req_s;
  logic [SELW-1:0]  pick_s;
  logic             sel_legal_s;

  rr_pick #(
    .NSRC (NSRC),
    .SELW (SELW)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_grant_r),
    .winner     (winner_s),
    .any_req    (any_req_s)
  );

  // Unpack the flat source bus into addressable words.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      src_word_s[i] = src_data[i*WIDTH +: WIDTH];
    end
  end

  assign sel_legal_s = (int'(read_en) < NSRC);

  // Next-state decode for all outputs and the round-robin history.
  always_comb begin
    grant_nxt_s      = {NSRC{1'b0}};
    busout_nxt_s     = busout_r;
    bus_valid_nxt_s  = 1'b0;
    bus_src_nxt_s    = bus_src_r;
    sel_err_nxt_s    = 1'b0;
    last_grant_nxt_s = last_grant_r;
    arb_hold_nxt_s   = 1'b0;
    pick_s           = winner_s;
    case (bus_mode_e'(mode))
      MODE_DIRECT: begin
        if (sel_valid) begin
          if (sel_legal_s) begin
            busout_nxt_s    = src_word_s[read_en];
            bus_src_nxt_s   = read_en;
            bus_valid_nxt_s = 1'b1;
            grant_nxt_s     = {{(NSRC-1){1'b0}}, 1'b1} << read_en;
          end else begin
            busout_nxt_s  = {WIDTH{1'b0}};
            bus_src_nxt_s = {SELW{1'b0}};
            sel_err_nxt_s = 1'b1;
          end
        end else begin
          busout_nxt_s  = busout_r;
          bus_src_nxt_s = bus_src_r;
        end
      end
      MODE_RR: begin
        if (any_req_s) begin
          // A locked owner that still requests keeps the bus ahead of the rotation.
          if (lock && arb_hold_r && req[last_grant_r]) begin
            pick_s = last_grant_r;
          end else begin
            pick_s = winner_s;
          end
          busout_nxt_s     = src_word_s[pick_s];
          bus_src_nxt_s    = pick_s;
          bus_valid_nxt_s  = 1'b1;
          grant_nxt_s      = {{(NSRC-1){1'b0}}, 1'b1} << pick_s;
          last_grant_nxt_s = pick_s;
          arb_hold_nxt_s   = 1'b1;
        end else begin
          busout_nxt_s  = busout_r;
          bus_src_nxt_s = bus_src_r;
        end
      end
      default: begin
        grant_nxt_s = {NSRC{1'b0}};
      end
    endcase
  end

  // Output and history registers; reset leaves source 0 first in line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_r      <= {NSRC{1'b0}};
      busout_r     <= {WIDTH{1'b0}};
      bus_valid_r  <= 1'b0;
      bus_src_r    <= {SELW{1'b0}};
      sel_err_r    <= 1'b0;
      last_grant_r <= SELW'(NSRC - 1);
      arb_hold_r   <= 1'b0;
    end else begin
      grant_r      <= grant_nxt_s;
      busout_r     <= busout_nxt_s;
      bus_valid_r  <= bus_valid_nxt_s;
      bus_src_r    <= bus_src_nxt_s;
      sel_err_r    <= sel_err_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      arb_hold_r   <= arb_hold_nxt_s;
    end
  end

  assign grant     = grant_r;
  assign busout    = busout_r;
  assign bus_valid = bus_valid_r;
  assign bus_src   = bus_src_r;
  assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: drives an 8-source and a 6-source bus_arb with shared stimulus and
// checks both against a behavioural model every cycle, plus literal expectations.
module tb_bus_arb;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         mode = 1'b0;
  logic [2:0]   read_en = 3'd0;
  logic         sel_valid = 1'b0;
  logic [127:0] src_data = 128'd0;
  logic [7:0]   req = 8'd0;
  logic         lock = 1'b0;

  logic [7:0]  grant8;
  logic [15:0] busout8;
  logic        valid8;
  logic [2:0]  src8;
  logic        err8;
  logic [5:0]  grant6;
  logic [15:0] busout6;
  logic        valid6;
  logic [2:0]  src6;
  logic        err6;

  int n_checks = 0;
  int n_pass   = 0;

  // model state per instance: index 0 = 8 sources, 1 = 6 sources
  logic [15:0] e_busout [2];
  int          e_src    [2];
  logic        e_valid  [2];
  logic        e_err    [2];
  logic [7:0]  e_grant  [2];
  int          e_last   [2];
  bit          e_hold   [2];

  always #5 clock = ~clock;

  bus_arb #(.WIDTH(16), .NSRC(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .mode(mode), .read_en(read_en),
    .sel_valid(sel_valid), .src_data(src_data), .req(req), .lock(lock),
    .grant(grant8), .busout(busout8), .bus_valid(valid8), .bus_src(src8), .sel_err(err8)
  );

  bus_arb #(.WIDTH(16), .NSRC(6)) dut6 (
    .clock(clock), .reset_n(reset_n), .mode(mode), .read_en(read_en),
    .sel_valid(sel_valid), .src_data(src_data[95:0]), .req(req[5:0]), .lock(lock),
    .grant(grant6), .busout(busout6), .bus_valid(valid6), .bus_src(src6), .sel_err(err6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      e_busout[k] = 16'd0; e_src[k] = 0; e_valid[k] = 1'b0; e_err[k] = 1'b0;
      e_grant[k] = 8'd0; e_hold[k] = 1'b0;
    end
    e_last[0] = 7;
    e_last[1] = 5;
  endtask

  // Next-cycle expectation from the behavioural rules for an n-source arbiter.
  task automatic model_step(input int k, input int n);
    logic [7:0] rq;
    int w;
    rq = req & 8'((1 << n) - 1);
    e_err[k] = 1'b0;
    e_valid[k] = 1'b0;
    e_grant[k] = 8'd0;
    if (mode == 1'b0) begin
      e_hold[k] = 1'b0;
      if (sel_valid) begin
        if (int'(read_en) < n) begin
          e_busout[k] = src_data[int'(read_en)*16 +: 16];
          e_src[k] = int'(read_en);
          e_valid[k] = 1'b1;
          e_grant[k] = 8'd1 << read_en;
        end else begin
          e_busout[k] = 16'd0;
          e_src[k] = 0;
          e_err[k] = 1'b1;
        end
      end
    end else if (rq == 8'd0) begin
      e_hold[k] = 1'b0;
    end else begin
      w = -1;
      if (lock && e_hold[k] && rq[e_last[k]]) w = e_last[k];
      for (int i = 1; i <= n; i++)
        if (w < 0 && rq[(e_last[k] + i) % n]) w = (e_last[k] + i) % n;
      e_busout[k] = src_data[w*16 +: 16];
      e_src[k] = w;
      e_valid[k] = 1'b1;
      e_grant[k] = 8'd1 << w;
      e_last[k] = w;
      e_hold[k] = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("grant8",  32'(grant8),  32'(e_grant[0]));
    check("busout8", 32'(busout8), 32'(e_busout[0]));
    check("valid8",  32'(valid8),  32'(e_valid[0]));
    check("src8",    32'(src8),    32'(e_src[0]));
    check("err8",    32'(err8),    32'(e_err[0]));
    check("grant6",  32'(grant6),  32'(e_grant[1][5:0]));
    check("busout6", 32'(busout6), 32'(e_busout[1]));
    check("valid6",  32'(valid6),  32'(e_valid[1]));
    check("src6",    32'(src6),    32'(e_src[1]));
    check("err6",    32'(err6),    32'(e_err[1]));
  endtask

  // Inputs are already set (1 time unit after an edge); advance one edge and compare.
  task automatic cycle();
    model_step(0, 8);
    model_step(1, 6);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  // Called 1 unit after a rising edge: asserts reset, checks async clear, releases.
  task automatic apply_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    compare_all();
  endtask

  task automatic rand_src();
    for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = $urandom;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 8; i++) src_data[i*16 +: 16] = 16'(16'h1000 + i * 16'h0111);
    @(posedge clock);
    #1;
    apply_reset();

    // direct select of source 2
    src_data[2*16 +: 16] = 16'hA5A5;
    mode = 1'b0; sel_valid = 1'b1; read_en = 3'd2;
    cycle();
    check("d033_busout", 32'(busout8), 32'h0000A5A5);
    check("d033_src",    32'(src8),    32'd2);
    check("d033_valid",  32'(valid8),  32'd1);
    check("d033_grant",  32'(grant8),  32'h04);

    // illegal select on the 6-source instance
    read_en = 3'd7;
    cycle();
    check("d034_err",    32'(err6),    32'd1);
    check("d034_busout", 32'(busout6), 32'd0);
    check("d034_valid",  32'(valid6),  32'd0);
    check("d034_grant",  32'(grant6),  32'd0);
    sel_valid = 1'b0;
    cycle();
    check("d034_err_pulse", 32'(err6), 32'd0);
    check("d034_hold_src8", 32'(src8), 32'd7);

    // full request rotation
    apply_reset();
    mode = 1'b1; req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cycle();
      check("d035_grant", 32'(grant8), 32'(8'd1 << (i % 8)));
      check("d035_valid", 32'(valid8), 32'd1);
    end

    // wrap-around alternation
    apply_reset();
    mode = 1'b1; req = 8'h81;
    cycle(); check("d036_g0", 32'(grant8), 32'h01);
    cycle(); check("d036_g1", 32'(grant8), 32'h80);
    cycle(); check("d036_g2", 32'(grant8), 32'h01);

    // lock holds source 1, release hands over to source 2
    apply_reset();
    mode = 1'b1; req = 8'h06; lock = 1'b0;
    cycle(); check("d037_first", 32'(grant8), 32'h02);
    lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(); check("d037_locked", 32'(grant8), 32'h02);
    end
    req = 8'h04;
    cycle(); check("d037_release", 32'(grant8), 32'h04);
    lock = 1'b0;

    // reset in the middle of arbitration
    req = 8'hFF;
    cycle(); cycle();
    apply_reset();
    check("d038_grant0", 32'(grant8),  32'd0);
    check("d038_busout", 32'(busout8), 32'd0);
    check("d038_valid",  32'(valid8),  32'd0);
    req = 8'h80;
    cycle(); check("d038_grant", 32'(grant8), 32'h80);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        apply_reset();
      end else begin
        if ($urandom_range(0, 7) == 0) mode = ~mode;
        read_en   = 3'($urandom_range(0, 7));
        sel_valid = ($urandom_range(0, 3) != 0);
        lock      = ($urandom_range(0, 1) != 0);
        case ($urandom_range(0, 3))
          0:       req = 8'd0;
          1:       req = 8'd1 << $urandom_range(0, 7);
          default: req = 8'($urandom);
        endcase
        rand_src();
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, bus data width in bits.
REQ-002 The block SHALL have parameter NSRC, default 8, number of bus sources (2..16).
REQ-003 The block SHALL have parameter SELW, default $clog2(NSRC), select/index width.
REQ-004 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port mode, input, 1, 0 = direct select, 1 = round-robin arbitration.
REQ-007 The block SHALL have port read_en, input, SELW, source index in direct mode.
REQ-008 The block SHALL have port sel_valid, input, 1, direct-mode transfer strobe.
REQ-009 The block SHALL have port src_data, input, NSRC*WIDTH, source i on bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port req, input, NSRC, per-source request in arbitration mode.
REQ-011 The block SHALL have port lock, input, 1, holds the current grant while its requester stays asserted.
REQ-012 The block SHALL have port grant, output, NSRC, registered one-hot grant, zero when idle.
REQ-013 The block SHALL have port busout, output, WIDTH, registered bus value.
REQ-014 The block SHALL have port bus_valid, output, 1, one-cycle pulse marking a new busout value.
REQ-015 The block SHALL have port bus_src, output, SELW, index of the source driving busout.
REQ-016 The block SHALL have port sel_err, output, 1, one-cycle pulse on an illegal direct select.

Function
REQ-017 All outputs SHALL be registered; latency from sampled control to busout/bus_valid SHALL be exactly one clock.
REQ-018 Direct mode, sel_valid=1, read_en<NSRC: next edge busout<=src_data[read_en], bus_src<=read_en, bus_valid<=1, grant<=one-hot(read_en).
REQ-019 Direct mode, sel_valid=1, read_en>=NSRC: busout<=0, bus_src<=0, bus_valid<=0, grant<=0, sel_err<=1.
REQ-020 Direct mode, sel_valid=0: busout and bus_src SHALL hold; bus_valid, sel_err, grant SHALL be 0; req SHALL be ignored.
REQ-021 Arbitration mode: with any req bit set, the winner SHALL be the first set bit searching upward from (last_grant+1) mod NSRC, wrapping around.
REQ-022 Arbitration winner k: next edge grant<=one-hot(k), busout<=src_data[k], bus_src<=k, bus_valid<=1, last_grant<=k.
REQ-023 Arbitration, lock=1 and req[last_grant]=1 with last_grant granted previous cycle: the same source SHALL be re-granted regardless of other requests.
REQ-024 Arbitration, req=0: grant<=0, bus_valid<=0, busout/bus_src/last_grant hold; sel_valid, read_en ignored; sel_err stays 0.
REQ-025 A single requester SHALL be granted every cycle it requests (no forced idle gaps).
REQ-026 mode SHALL be sampled each cycle; a change takes effect on the next edge with no lost or duplicated transfer; last_grant SHALL persist across mode changes.
REQ-027 Direct-mode transfers SHALL NOT update last_grant.
REQ-028 grant SHALL never have more than one bit set.

Reset
REQ-029 On reset_n=0, asynchronously: busout=0, bus_src=0, bus_valid=0, sel_err=0, grant=0, last_grant=NSRC-1 (so source 0 has first priority).
REQ-030 Reset asserted mid-transfer SHALL abort it; first transfer after release SHALL follow REQ-018..REQ-024 from reset state.

Structure
REQ-031 A shared package bus_pkg SHALL hold default WIDTH/NSRC constants and the mode encodings MODE_DIRECT=0, MODE_RR=1.
REQ-032 The round-robin priority search SHALL be a combinational sub-module rr_pick (inputs req, last_grant; outputs winner index, any_req).

Verification
REQ-033 Reset release, mode=0, sel_valid=1, read_en=2, src_data[2]=16'hA5A5 -> next cycle busout=16'hA5A5, bus_src=2, bus_valid=1, grant=8'b0000_0100.
REQ-034 NSRC=6, mode=0, read_en=7, sel_valid=1 -> sel_err=1 one cycle, busout=0, bus_valid=0, grant=0.
REQ-035 mode=1, req=8'hFF held 9 cycles after reset -> grants 0,1,...,7,0 in consecutive cycles, bus_valid=1 each cycle.
REQ-036 mode=1, req=8'b1000_0001, last_grant=7 -> grant source 0, then 7, then 0 (wrap-around alternation).
REQ-037 mode=1, lock=1, req=8'b0000_0110, source 1 granted -> source 1 re-granted while req[1]=1; drop req[1] -> source 2 granted next cycle.
REQ-038 reset_n pulsed low during arbitration -> all outputs 0 immediately; after release with req=8'h80 -> grant=8'h80 next cycle.
